arq_seqn_ctrl: RTL
==================

Name: arq_seqn_ctrl

Overview:
Per-LT_ADDR ARQ/SEQN controller for the packet header path in connection state. It owns the 8-entry txaclSEQN/txARQN vectors that the header builder inserts into outgoing headers, and tracks outstanding CRC packets. It consumes decoded header/CRC results to decide ACK/NAK, duplicate rejection and retransmission. It sits between the header bit processor and the link-layer payload buffers.

Parameters:
RX_WIN_US, 11'd1250, response window in p_1us ticks after tx_done_p before a missing reply counts as NAK
WIN_W, 11, width of window counter

Ports:
clk_6M  input  1  system clock, 6 MHz
rst  input  1  asynchronous active-high reset
p_1us  input  1  1 us tick, one clk_6M cycle wide
conns  input  1  connection state; low = synchronous clear of all state to reset values
tx_done_p  input  1  outgoing header+payload finished (one cycle)
tx_lt_addr  input  3  LT_ADDR of the packet just sent
tx_pktype  input  4  type of the packet just sent
rx_hdr_done_p  input  1  header HEC check complete (one cycle)
dec_hecgood  input  1  HEC result, valid with rx_hdr_done_p
dec_lt_addr  input  3  decoded LT_ADDR
dec_pk_type  input  4  decoded type
dec_seqn  input  1  decoded SEQN
dec_arqn_bit  input  1  decoded ARQN
rx_crc_done_p  input  1  payload CRC check complete (one cycle, after rx_hdr_done_p)
rx_crcgood  input  1  CRC result
flush_p  input  1  flush request (one cycle)
flush_lt  input  3  LT_ADDR to flush
txaclSEQN  output  8  SEQN per LT_ADDR
txARQN  output  8  ARQN per LT_ADDR
pending  output  8  CRC packet outstanding, awaiting ACK, per LT_ADDR
retx_req  output  8  retransmit required per LT_ADDR
rx_accept_p  output  1  new payload accepted (one cycle)
rx_dup_p  output  1  duplicate payload discarded (one cycle)
resp_timeout_p  output  1  window expired without valid header (one cycle)

Behaviour:
- Reset/conns low: txaclSEQN=8'hFF, txARQN=8'h00, pending=0, retx_req=0, pulses 0, last_rx_seqn=8'h00, FSM IDLE.
- needs_crc(type) = type not in {0,1,5,6,7}.
- Global FSM: IDLE -> RX_WAIT on tx_done_p; RX_WAIT -> HDR_EVAL on rx_hdr_done_p; RX_WAIT -> IDLE on window expiry; HDR_EVAL -> CRC_WAIT if HEC good and needs_crc(dec_pk_type), else IDLE; CRC_WAIT -> IDLE on rx_crc_done_p or tx_done_p (abort, no ARQN change). Captures decoded fields on rx_hdr_done_p.
- tx_done_p: if needs_crc(tx_pktype): pending[tx_lt_addr]<=1, retx_req[tx_lt_addr]<=0. Window counter loads 0, increments on p_1us in RX_WAIT; expiry when counter==RX_WIN_US-1 and p_1us.
- Expiry: resp_timeout_p=1 next cycle; retx_req<=pending (all set bits).
- rx_hdr_done_p with dec_hecgood=0: no field updates, retx_req<=pending, FSM IDLE.
- HEC good, lt=dec_lt_addr: if pending[lt] & dec_arqn_bit: pending[lt]<=0, retx_req[lt]<=0, txaclSEQN[lt] toggles; if pending[lt] & !dec_arqn_bit: retx_req[lt]<=1, SEQN unchanged. Non-CRC types (NULL/POLL) carry ARQN too; processed identically; no txARQN change.
- rx_crc_done_p in CRC_WAIT: CRC bad -> txARQN[lt]<=0. CRC good: txARQN[lt]<=1; if dec_seqn != last_rx_seqn[lt] -> rx_accept_p, last_rx_seqn[lt]<=dec_seqn; else rx_dup_p (still ACK).
- Pulse outputs registered, asserted exactly one cycle, one cycle after triggering strobe.
- flush_p: pending[flush_lt]<=0, retx_req[flush_lt]<=0, txaclSEQN[flush_lt] toggles. Flush beats any same-cycle update to that lt; updates to other lt proceed.
- tx_done_p coinciding with rx_crc_done_p: both applied (disjoint fields); FSM goes to RX_WAIT.
- Counter saturates; no wrap. Entry widths fixed 8 LT addresses; lt 0 (broadcast) treated like others.

Test Plan:
- Reset -> txaclSEQN=FF, txARQN=00, pending=00; conns low mid-RX_WAIT -> same values next cycle.
- tx_done_p lt=3 type=4 (DH1), rx header hecgood lt=3 arqn=1 -> pending[3] 1->0, txaclSEQN=F7.
- Same with arqn=0 -> retx_req[3]=1, SEQN unchanged, pending[3] stays 1.
- tx_done_p lt=2, no rx for 1250 p_1us -> resp_timeout_p once, retx_req[2]=1.
- Rx DH1 lt=1 seqn=1 crc good twice -> first rx_accept_p, second rx_dup_p, txARQN[1]=1 both; then crc bad -> txARQN[1]=0.
- flush_p lt=5 same cycle as ACK for lt=5 -> SEQN[5] toggles once, pending[5]=0.

Source files
------------

// File: rtl/arq_seqn_ctrl.sv
// Per-LT_ADDR ARQ/SEQN bookkeeping for the connection-state header path.
// A single global FSM follows each transmit -> response header -> CRC exchange.
module arq_seqn_ctrl #(
  parameter int               WIN_W     = 11,
  parameter logic [WIN_W-1:0] RX_WIN_US = 11'd1250
) (
  input  logic       clk_6M,
  input  logic       rst,
  input  logic       p_1us,
  input  logic       conns,
  input  logic       tx_done_p,
  input  logic [2:0] tx_lt_addr,
  input  logic [3:0] tx_pktype,
  input  logic       rx_hdr_done_p,
  input  logic       dec_hecgood,
  input  logic [2:0] dec_lt_addr,
  input  logic [3:0] dec_pk_type,
  input  logic       dec_seqn,
  input  logic       dec_arqn_bit,
  input  logic       rx_crc_done_p,
  input  logic       rx_crcgood,
  input  logic       flush_p,
  input  logic [2:0] flush_lt,
  output logic [7:0] txaclSEQN,
  output logic [7:0] txARQN,
  output logic [7:0] pending,
  output logic [7:0] retx_req,
  output logic       rx_accept_p,
  output logic       rx_dup_p,
  output logic       resp_timeout_p
);

  typedef enum logic [1:0] {IDLE, RX_WAIT, HDR_EVAL, CRC_WAIT} state_t;

  state_t           state_q, state_d;
  logic [7:0]       seqn_q, seqn_d;
  logic [7:0]       arqn_q, arqn_d;
  logic [7:0]       pend_q, pend_d;
  logic [7:0]       retx_q, retx_d;
  logic [7:0]       last_q, last_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [2:0]       cap_lt_q, cap_lt_d;
  logic [3:0]       cap_type_q, cap_type_d;
  logic             cap_seqn_q, cap_seqn_d;
  logic             cap_hec_q, cap_hec_d;
  logic             accept_q, accept_d;
  logic             dup_q, dup_d;
  logic             tmo_q, tmo_d;
  logic             expire;

  // NULL, POLL, FHS-free SCO-class types (5..7) carry no CRC'd payload.
  function automatic logic needs_crc(input logic [3:0] t);
    return !(t inside {4'd0, 4'd1, 4'd5, 4'd6, 4'd7});
  endfunction

  assign expire = (state_q == RX_WAIT) && p_1us && (win_q == RX_WIN_US - 1'b1);

  always_comb begin
    state_d    = state_q;
    seqn_d     = seqn_q;
    arqn_d     = arqn_q;
    pend_d     = pend_q;
    retx_d     = retx_q;
    last_d     = last_q;
    win_d      = win_q;
    cap_lt_d   = cap_lt_q;
    cap_type_d = cap_type_q;
    cap_seqn_d = cap_seqn_q;
    cap_hec_d  = cap_hec_q;
    accept_d   = 1'b0;
    dup_d      = 1'b0;
    tmo_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_done_p) state_d = RX_WAIT;
      end
      RX_WAIT: begin
        if (rx_hdr_done_p) begin
          state_d    = HDR_EVAL;
          cap_lt_d   = dec_lt_addr;
          cap_type_d = dec_pk_type;
          cap_seqn_d = dec_seqn;
          cap_hec_d  = dec_hecgood;
          if (!dec_hecgood) begin
            retx_d = pend_q;
          end else if (pend_q[dec_lt_addr]) begin
            if (dec_arqn_bit) begin
              pend_d[dec_lt_addr] = 1'b0;
              retx_d[dec_lt_addr] = 1'b0;
              seqn_d[dec_lt_addr] = ~seqn_q[dec_lt_addr];
            end else begin
              retx_d[dec_lt_addr] = 1'b1;
            end
          end
        end else if (tx_done_p) begin
          state_d = RX_WAIT;
        end else if (expire) begin
          tmo_d   = 1'b1;
          retx_d  = pend_q;
          state_d = IDLE;
        end else if (p_1us && (win_q != {WIN_W{1'b1}})) begin
          win_d = win_q + 1'b1;
        end
      end
      HDR_EVAL: begin
        if (tx_done_p)
          state_d = RX_WAIT;
        else if (cap_hec_q && needs_crc(cap_type_q))
          state_d = CRC_WAIT;
        else
          state_d = IDLE;
      end
      CRC_WAIT: begin
        if (rx_crc_done_p) begin
          state_d = tx_done_p ? RX_WAIT : IDLE;
          if (rx_crcgood) begin
            arqn_d[cap_lt_q] = 1'b1;
            if (cap_seqn_q != last_q[cap_lt_q]) begin
              accept_d         = 1'b1;
              last_d[cap_lt_q] = cap_seqn_q;
            end else begin
              dup_d = 1'b1;
            end
          end else begin
            arqn_d[cap_lt_q] = 1'b0;
          end
        end else if (tx_done_p) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tx_done_p) begin
      win_d = '0;
      if (needs_crc(tx_pktype)) begin
        pend_d[tx_lt_addr] = 1'b1;
        retx_d[tx_lt_addr] = 1'b0;
      end
    end

    // Flush is applied last so it overrides any same-cycle update to its LT_ADDR.
    if (flush_p) begin
      pend_d[flush_lt] = 1'b0;
      retx_d[flush_lt] = 1'b0;
      seqn_d[flush_lt] = ~seqn_q[flush_lt];
    end

    if (!conns) begin
      state_d    = IDLE;
      seqn_d     = 8'hFF;
      arqn_d     = 8'h00;
      pend_d     = 8'h00;
      retx_d     = 8'h00;
      last_d     = 8'h00;
      win_d      = '0;
      cap_lt_d   = 3'd0;
      cap_type_d = 4'd0;
      cap_seqn_d = 1'b0;
      cap_hec_d  = 1'b0;
      accept_d   = 1'b0;
      dup_d      = 1'b0;
      tmo_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      seqn_q     <= 8'hFF;
      arqn_q     <= 8'h00;
      pend_q     <= 8'h00;
      retx_q     <= 8'h00;
      last_q     <= 8'h00;
      win_q      <= '0;
      cap_lt_q   <= 3'd0;
      cap_type_q <= 4'd0;
      cap_seqn_q <= 1'b0;
      cap_hec_q  <= 1'b0;
      accept_q   <= 1'b0;
      dup_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seqn_q     <= seqn_d;
      arqn_q     <= arqn_d;
      pend_q     <= pend_d;
      retx_q     <= retx_d;
      last_q     <= last_d;
      win_q      <= win_d;
      cap_lt_q   <= cap_lt_d;
      cap_type_q <= cap_type_d;
      cap_seqn_q <= cap_seqn_d;
      cap_hec_q  <= cap_hec_d;
      accept_q   <= accept_d;
      dup_q      <= dup_d;
      tmo_q      <= tmo_d;
    end
  end

  assign txaclSEQN      = seqn_q;
  assign txARQN         = arqn_q;
  assign pending        = pend_q;
  assign retx_req       = retx_q;
  assign rx_accept_p    = accept_q;
  assign rx_dup_p       = dup_q;
  assign resp_timeout_p = tmo_q;

endmodule
